// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: shares the single DDR burst command port between the
// instruction-fetch, data-cache fill, jump-vector fetch and store clients.
// Requests latch as pending, one winner is chosen by fixed priority with an
// anti-starvation override for instruction fetch, and a single command is
// outstanding until its burst completes.
module ddr_req_arbiter #(
    parameter int unsigned DDR_ADDR_WIDTH   = 28,
    parameter int unsigned DATA_CACHE_DEPTH = 16,
    parameter int unsigned STARVE_LIMIT     = 4
) (
    input  logic                      mem_clk,
    input  logic                      rst,
    input  logic                      init_done,
    input  logic                      ins_req,
    input  logic [DDR_ADDR_WIDTH-1:0] ins_addr,
    input  logic [7:0]                ins_len,
    input  logic                      data_rd_req,
    input  logic [DDR_ADDR_WIDTH-1:0] data_rd_addr,
    input  logic                      jmp_req,
    input  logic [DDR_ADDR_WIDTH-1:0] jmp_addr,
    input  logic                      store_req,
    input  logic [DDR_ADDR_WIDTH-1:0] store_addr,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [1:0]                cmd_type,
    output logic [DDR_ADDR_WIDTH-1:0] cmd_addr,
    output logic [9:0]                cmd_len,
    input  logic                      cmd_done,
    output logic [3:0]                grant,
    output logic [3:0]                done,
    output logic                      busy,
    output logic                      proto_err
);

    // Requester indices double as cmd_type codes and grant/done bit positions.
    localparam logic [1:0] ID_INS   = 2'd0;
    localparam logic [1:0] ID_DATA  = 2'd1;
    localparam logic [1:0] ID_JMP   = 2'd2;
    localparam logic [1:0] ID_STORE = 2'd3;

    localparam logic [2:0]                STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic [9:0]                DATA_LEN   = 10'(DATA_CACHE_DEPTH + 1);
    localparam logic [9:0]                STORE_LEN  = 10'(DATA_CACHE_DEPTH);
    localparam logic [9:0]                JMP_LEN    = 10'd1;
    localparam logic [DDR_ADDR_WIDTH-1:0] STORE_OFS  = DDR_ADDR_WIDTH'(8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [3:0]                req_vec;
    logic [3:0]                pend;
    logic [3:0]                pend_set;
    logic [DDR_ADDR_WIDTH-1:0] ins_addr_q;
    logic [DDR_ADDR_WIDTH-1:0] data_addr_q;
    logic [DDR_ADDR_WIDTH-1:0] jmp_addr_q;
    logic [DDR_ADDR_WIDTH-1:0] store_addr_q;
    logic [7:0]                ins_len_q;
    logic [2:0]                starve_cnt;
    logic [1:0]                win;
    logic                      start;

    assign req_vec = {store_req, jmp_req, data_rd_req, ins_req};

    // A request captures when its pending bit is clear, or in its own done
    // cycle, where a fresh request overrides the clear.
    assign pend_set = req_vec & (~pend | done);

    // Pending bits and the request fields captured alongside them.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            pend         <= '0;
            ins_addr_q   <= '0;
            data_addr_q  <= '0;
            jmp_addr_q   <= '0;
            store_addr_q <= '0;
            ins_len_q    <= '0;
        end else begin
            pend <= pend_set | (pend & ~done);
            if (pend_set[ID_INS]) begin
                ins_addr_q <= ins_addr;
                ins_len_q  <= ins_len;
            end
            if (pend_set[ID_DATA]) begin
                data_addr_q <= data_rd_addr;
            end
            if (pend_set[ID_JMP]) begin
                jmp_addr_q <= jmp_addr;
            end
            if (pend_set[ID_STORE]) begin
                store_addr_q <= store_addr;
            end
        end
    end

    // Winner selection: starved instruction fetch first, then fixed priority.
    always_comb begin
        win = ID_INS;
        if (pend[ID_INS] && (starve_cnt == STARVE_MAX)) begin
            win = ID_INS;
        end else if (pend[ID_DATA]) begin
            win = ID_DATA;
        end else if (pend[ID_JMP]) begin
            win = ID_JMP;
        end else if (pend[ID_STORE]) begin
            win = ID_STORE;
        end
    end

    // State register.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start marks the cycle a new grant is made.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_done && (|pend)) begin
                    state_next = S_ISSUE;
                    start      = 1'b1;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cmd_done) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered command, grant, completion, busy and protocol-error outputs.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            cmd_valid  <= 1'b0;
            cmd_type   <= '0;
            cmd_addr   <= '0;
            cmd_len    <= '0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            done <= '0;
            busy <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cmd_valid <= 1'b1;
                        cmd_type  <= win;
                        grant     <= 4'b0001 << win;
                        case (win)
                            ID_INS: begin
                                cmd_addr <= ins_addr_q;
                                cmd_len  <= {2'b00, ins_len_q};
                            end
                            ID_DATA: begin
                                cmd_addr <= data_addr_q;
                                cmd_len  <= DATA_LEN;
                            end
                            ID_JMP: begin
                                cmd_addr <= jmp_addr_q;
                                cmd_len  <= JMP_LEN;
                            end
                            default: begin
                                cmd_addr <= store_addr_q + STORE_OFS;
                                cmd_len  <= STORE_LEN;
                            end
                        endcase
                        if (win == ID_INS) begin
                            starve_cnt <= '0;
                        end else if (pend[ID_INS] && (starve_cnt < STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 3'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cmd_done) begin
                        done <= grant;
                    end
                end
                S_DONE: begin
                    grant <= '0;
                end
                default: begin
                    grant <= '0;
                end
            endcase
            if (cmd_done && (state != S_WAIT)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb_ddr_req_arbiter: directed and randomized checks of ddr_req_arbiter,
// acting as the DDR interface and the four clients.
module tb_ddr_req_arbiter;

    localparam int unsigned AW    = 28;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LIMIT = 4;

    logic          mem_clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          ins_req;
    logic [AW-1:0] ins_addr;
    logic [7:0]    ins_len;
    logic          data_rd_req;
    logic [AW-1:0] data_rd_addr;
    logic          jmp_req;
    logic [AW-1:0] jmp_addr;
    logic          store_req;
    logic [AW-1:0] store_addr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [9:0]    cmd_len;
    logic          cmd_done;
    logic [3:0]    grant;
    logic [3:0]    done;
    logic          busy;
    logic          proto_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending flags, captured fields, starvation count.
    bit            mp [4];
    logic [AW-1:0] ma [4];
    logic [7:0]    ml;
    int unsigned   ms;

    ddr_req_arbiter #(
        .DDR_ADDR_WIDTH   (AW),
        .DATA_CACHE_DEPTH (DEPTH),
        .STARVE_LIMIT     (LIMIT)
    ) dut (
        .mem_clk      (mem_clk),
        .rst          (rst),
        .init_done    (init_done),
        .ins_req      (ins_req),
        .ins_addr     (ins_addr),
        .ins_len      (ins_len),
        .data_rd_req  (data_rd_req),
        .data_rd_addr (data_rd_addr),
        .jmp_req      (jmp_req),
        .jmp_addr     (jmp_addr),
        .store_req    (store_req),
        .store_addr   (store_addr),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_done     (cmd_done),
        .grant        (grant),
        .done         (done),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        ins_req     = m[0];
        data_rd_req = m[1];
        jmp_req     = m[2];
        store_req   = m[3];
        tick();
        ins_req     = 1'b0;
        data_rd_req = 1'b0;
        jmp_req     = 1'b0;
        store_req   = 1'b0;
    endtask

    task automatic rst_dut();
        rst         = 1'b1;
        ins_req     = 1'b0;
        data_rd_req = 1'b0;
        jmp_req     = 1'b0;
        store_req   = 1'b0;
        cmd_ready   = 1'b0;
        cmd_done    = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Waits for a command, checks it, completes the handshake and burst, and
    // optionally re-pulses requests (redo) during the done cycle.
    task automatic serve(input string tag, input logic [1:0] et, input logic [AW-1:0] ea,
                         input logic [9:0] el, input logic [3:0] redo, output int waited);
        waited = 0;
        while (!cmd_valid && waited < 12) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, 32'(cmd_valid), 1);
        chk({tag, "_type"},  32'(cmd_type),  32'(et));
        chk({tag, "_addr"},  32'(cmd_addr),  32'(ea));
        chk({tag, "_len"},   32'(cmd_len),   32'(el));
        chk({tag, "_grant"}, 32'(grant),     32'(1) << et);
        tick();
        chk({tag, "_hold"}, 32'(cmd_valid), 1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk({tag, "_vdrop"}, 32'(cmd_valid), 0);
        repeat ($urandom_range(1, 3)) tick();
        chk({tag, "_wgrant"}, 32'(grant), 32'(1) << et);
        chk({tag, "_wdone"},  32'(done),  0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'(1) << et);
        pulse(redo);
        chk({tag, "_done1"}, 32'(done),      0);
        chk({tag, "_gclr"},  32'(grant),     0);
        chk({tag, "_idle"},  32'(cmd_valid), 0);
    endtask

    function automatic logic [AW-1:0] cur_addr(input int i);
        case (i)
            0:       return ins_addr;
            1:       return data_rd_addr;
            2:       return jmp_addr;
            default: return store_addr;
        endcase
    endfunction

    task automatic capture(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i] && !mp[i]) begin
                mp[i] = 1'b1;
                ma[i] = cur_addr(i);
                if (i == 0) ml = ins_len;
            end
        end
    endtask

    task automatic rand_fields();
        ins_addr     = AW'($urandom);
        ins_len      = 8'($urandom);
        data_rd_addr = AW'($urandom);
        jmp_addr     = AW'($urandom);
        store_addr   = AW'($urandom);
    endtask

    function automatic logic [1:0] pick();
        if (mp[0] && ms == LIMIT) return 2'd0;
        if (mp[1]) return 2'd1;
        if (mp[2]) return 2'd2;
        if (mp[3]) return 2'd3;
        return 2'd0;
    endfunction

    initial begin
        int            wt;
        logic [1:0]    w;
        logic [3:0]    m;
        logic [AW-1:0] ea;
        logic [9:0]    el;

        init_done    = 1'b0;
        ins_addr     = '0;
        ins_len      = '0;
        data_rd_addr = '0;
        jmp_addr     = '0;
        store_addr   = '0;
        rst_dut();

        // Reset state
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_type",  32'(cmd_type),  0);
        chk("rst_addr",  32'(cmd_addr),  0);
        chk("rst_len",   32'(cmd_len),   0);
        chk("rst_grant", 32'(grant),     0);
        chk("rst_done",  32'(done),      0);
        chk("rst_busy",  32'(busy),      0);
        chk("rst_perr",  32'(proto_err), 0);
        chk("rst_starve", 32'(dut.starve_cnt), 0);

        // Gating by init_done
        ins_addr = 28'h0000100;
        ins_len  = 8'd72;
        pulse(4'b0001);
        repeat (4) tick();
        chk("gate_novalid", 32'(cmd_valid), 0);
        chk("gate_nogrant", 32'(grant),     0);
        init_done = 1'b1;
        serve("gate", 2'd0, 28'h0000100, 10'd72, 4'b0000, wt);
        chk("gate_lat", 32'(wt), 1);

        // Simultaneous requests: priority order and turnaround
        rst_dut();
        data_rd_addr = 28'h0000200;
        jmp_addr     = 28'h0000300;
        store_addr   = 28'h0000400;
        ins_addr     = 28'h0000500;
        ins_len      = 8'd8;
        pulse(4'b1111);
        chk("sim_t1", 32'(cmd_valid), 0);
        serve("sim_data", 2'd1, 28'h0000200, 10'd17, 4'b0000, wt);
        chk("sim_lat", 32'(wt), 1);
        serve("sim_jmp", 2'd2, 28'h0000300, 10'd1, 4'b0000, wt);
        chk("sim_turn", 32'(wt), 1);
        serve("sim_store", 2'd3, 28'h0000408, 10'd16, 4'b0000, wt);
        serve("sim_ins", 2'd0, 28'h0000500, 10'd8, 4'b0000, wt);
        chk("sim_starve0", 32'(dut.starve_cnt), 0);

        // Store address offset and wrap
        store_addr = 28'h0008010;
        pulse(4'b1000);
        serve("st_off", 2'd3, 28'h0008018, 10'd16, 4'b0000, wt);
        store_addr = 28'hFFFFFFC;
        pulse(4'b1000);
        serve("st_wrap", 2'd3, 28'h0000004, 10'd16, 4'b0000, wt);

        // Starvation of instruction fetch
        rst_dut();
        ins_addr     = 28'h0001000;
        ins_len      = 8'd200;
        data_rd_addr = 28'h0002000;
        pulse(4'b0011);
        for (int k = 0; k < 4; k++) begin
            serve("stv_data", 2'd1, 28'h0002000, 10'd17, 4'b0010, wt);
        end
        chk("stv_cnt4", 32'(dut.starve_cnt), 4);
        serve("stv_ins", 2'd0, 28'h0001000, 10'd200, 4'b0000, wt);
        chk("stv_cnt0", 32'(dut.starve_cnt), 0);
        serve("stv_after", 2'd1, 28'h0002000, 10'd17, 4'b0000, wt);

        // Re-request in own done cycle
        rst_dut();
        data_rd_addr = 28'h0003000;
        pulse(4'b0010);
        data_rd_addr = 28'h0003100;
        serve("rrq_a", 2'd1, 28'h0003000, 10'd17, 4'b0010, wt);
        serve("rrq_b", 2'd1, 28'h0003100, 10'd17, 4'b0000, wt);
        chk("rrq_lat", 32'(wt), 1);

        // cmd_done during ISSUE
        rst_dut();
        jmp_addr = 28'h0004000;
        pulse(4'b0100);
        tick();
        chk("pe_valid", 32'(cmd_valid), 1);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("pe_flag",  32'(proto_err), 1);
        chk("pe_issue", 32'(cmd_valid), 1);
        chk("pe_done",  32'(done),      0);
        serve("pe_fin", 2'd2, 28'h0004000, 10'd1, 4'b0000, wt);
        chk("pe_sticky", 32'(proto_err), 1);

        // Reset during WAIT
        rst_dut();
        ins_addr = 28'h0005000;
        ins_len  = 8'd4;
        pulse(4'b0001);
        tick();
        chk("mr_valid", 32'(cmd_valid), 1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("mr_wait", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_valid0", 32'(cmd_valid), 0);
        chk("mr_grant0", 32'(grant),     0);
        chk("mr_busy0",  32'(busy),      0);
        chk("mr_addr0",  32'(cmd_addr),  0);
        chk("mr_len0",   32'(cmd_len),   0);
        @(posedge mem_clk);
        #1 rst = 1'b0;
        repeat (4) tick();
        chk("mr_noreq", 32'(cmd_valid), 0);
        chk("mr_nobusy", 32'(busy), 0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("mr_idle_perr", 32'(proto_err), 1);

        // Randomized traffic against the reference model
        rst_dut();
        for (int i = 0; i < 4; i++) mp[i] = 1'b0;
        ms = 0;
        ml = '0;
        for (int it = 0; it < 40; it++) begin
            rand_fields();
            if (!(mp[0] || mp[1] || mp[2] || mp[3])) begin
                m = 4'($urandom_range(1, 15));
                capture(m);
                pulse(m);
                rand_fields();
            end
            w = pick();
            case (w)
                2'd0: begin ea = ma[0];          el = {2'b00, ml};   end
                2'd1: begin ea = ma[1];          el = 10'(DEPTH + 1); end
                2'd2: begin ea = ma[2];          el = 10'd1;         end
                default: begin ea = ma[3] + AW'(8); el = 10'(DEPTH); end
            endcase
            if (w == 2'd0) ms = 0;
            else if (mp[0] && ms < LIMIT) ms++;
            m = 4'($urandom_range(0, 15));
            serve("rnd", w, ea, el, m, wt);
            mp[w] = 1'b0;
            capture(m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_req_arbiter.md
# ddr_req_arbiter

Sequences and shares the single DDR burst command port between the four DDR clients: instruction-cache fill, data-cache fill, interrupt-vector (jump address) fetch and data-cache store. Requests are latched as pending. One winner is picked by fixed priority, with an anti-starvation override for the instruction fetch. The arbiter issues one command at a time to the DDR cache interface and waits for burst completion before it picks the next winner. Nothing is granted until the DDR preload sequence reports completion.

## Interface
Parameters:
- DDR_ADDR_WIDTH, 28, width of DDR word addresses
- DATA_CACHE_DEPTH, 16, data-cache line length in DDR words
- STARVE_LIMIT, 4, number of consecutive non-instruction grants after which a pending instruction fetch wins

Ports:
- mem_clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- init_done  in  1  DDR preload finished; no grants while low
- ins_req  in  1  instruction fetch request
- ins_addr  in  DDR_ADDR_WIDTH  instruction fetch address
- ins_len  in  8  instruction fetch length
- data_rd_req  in  1  data-cache fill request
- data_rd_addr  in  DDR_ADDR_WIDTH  data-cache fill address
- jmp_req  in  1  jump-vector fetch request
- jmp_addr  in  DDR_ADDR_WIDTH  jump-vector fetch address
- store_req  in  1  data-cache store request
- store_addr  in  DDR_ADDR_WIDTH  data-cache store address
- cmd_valid  out  1  command presented to the DDR interface
- cmd_ready  in  1  command accepted
- cmd_type  out  2  command type: 0 = ISA read, 1 = data read, 2 = jump read, 3 = store
- cmd_addr  out  DDR_ADDR_WIDTH  burst start address
- cmd_len  out  10  burst length
- cmd_done  in  1  single-cycle burst-finish pulse
- grant  out  4  one-hot current owner, bit order {store, jmp, data_rd, ins}
- done  out  4  single-cycle completion pulse, same bit order as grant
- busy  out  1  high whenever the state machine is not in IDLE
- proto_err  out  1  sticky flag: cmd_done arrived outside WAIT

## Operation
- Pending capture: a requester's pending bit sets on any cycle its req is high and the bit is clear. Its address and length are captured in the same cycle. While the bit is set, further req and address changes are ignored.
- Pending clear: in the cycle that requester's done pulse is driven. If req is high in that same cycle, the bit re-sets and the new address is captured; set wins over clear.
- Priority order: data_rd > jmp > store > ins.
- Anti-starvation: starve_cnt (3 bits, saturating at STARVE_LIMIT) increments on every grant to a non-ins requester while ins is pending. It clears when ins is granted. When starve_cnt equals STARVE_LIMIT and ins is pending, ins wins.
- Command fields per winner:
  - ins: cmd_len = zero-extended captured length.
  - data_rd: cmd_len = DATA_CACHE_DEPTH + 1.
  - jmp: cmd_len = 1.
  - store: cmd_addr = store_addr + 8, modulo 2^DDR_ADDR_WIDTH (wraps); cmd_len = DATA_CACHE_DEPTH.
  - Other requesters: cmd_addr = captured address unchanged.
- FSM states:
  - IDLE: if init_done is high and any pending bit is set, select the winner, load the cmd_* registers and grant, and go to ISSUE. Otherwise stay.
  - ISSUE: cmd_valid = 1. On cmd_ready go to WAIT and drop cmd_valid.
  - WAIT: on cmd_done go to DONE.
  - DONE: pulse done[winner], clear that pending bit, clear grant, go to IDLE.
- A cmd_done received in IDLE, ISSUE or DONE is ignored and sets proto_err. proto_err clears only on rst.
- init_done falling mid-transaction: the current command completes normally. No new grant is made until init_done is high again. Pending bits keep accumulating meanwhile.

## Timing
- Reset: the following are 0 and state is IDLE: cmd_valid, cmd_type, cmd_addr, cmd_len, grant, done, busy, proto_err, all pending bits, starve_cnt.
- Every output is registered.
- Request pulse at cycle T:
  - pending is set at T+1.
  - cmd_valid and grant are asserted at T+2 when the arbiter is idle and init_done is high.
- cmd_* and grant are stable from ISSUE entry through DONE.
- cmd_ready sampled in cycle C means cmd_valid is low at C+1.
- cmd_done at cycle D means done pulses at D+1, and the earliest next cmd_valid is at D+3 (IDLE at D+2).
- Minimum turnaround between two back-to-back commands: 4 cycles.

## Test plan
- Gating: reset; pulse ins_req with ins_addr = 0x0000100 and ins_len = 72 while init_done = 0 → no cmd_valid. Raise init_done → cmd_valid with type 0, addr 0x0000100, len 72, grant = 4'b0001. Then cmd_ready and cmd_done → done = 4'b0001 for exactly 1 cycle.
- Simultaneous requests: pulse all four reqs in the same cycle → grant order data_rd (len 17), jmp (len 1), store, ins.
- Store address: store_addr = 0x0008010 → cmd_addr = 0x0008018, len 16. store_addr = 0xFFFFFFC → cmd_addr = 0x0000004.
- Starvation: keep ins pending and re-pulse data_rd at each of its done cycles → exactly 4 data_rd grants, then ins is granted, then starve_cnt = 0.
- Re-request: assert data_rd_req in its own DONE cycle with a new address → pending stays set and the next command uses the new address. Separately, cmd_done while in ISSUE → proto_err = 1 and the FSM stays in ISSUE.
- Reset mid-operation: assert rst during WAIT → all outputs 0 and IDLE on the same edge. After release with no reqs → no cmd_valid.
